pid_filter_mc: RTL and testbench

//   Time-multiplexed, N-channel PID filter. It sits between the oversample filter (OSF) and
//   the router/OPP stage of pid_controller, and computes
//     u = p*e + i*sum(e) + d*(e - e_prev),  with e = setpoint - x,

---
 rtl/pid_filter_mc_if.sv | 24 ++
 rtl/pid_filter_mc.sv | 174 +++++++++++++++++
 tb/tb_pid_filter_mc.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pid_filter_mc_if.sv
// rtl/pid_filter_mc_if.sv - sample/result stream bundle for pid_filter_mc
interface pid_filter_mc_if #(
  parameter int W_CHAN = 3,
  parameter int W_IN   = 18,
  parameter int W_OUT  = 48
);
  logic                    data_valid_in;
  logic [W_CHAN-1:0]       chan_in;
  logic signed [W_IN-1:0]  data_in;
  logic                    data_valid_out;
  logic [W_CHAN-1:0]       chan_out;
  logic signed [W_OUT-1:0] data_out;
  logic                    sat_out;

  modport master (
    output data_valid_in, chan_in, data_in,
    input  data_valid_out, chan_out, data_out, sat_out
  );

  modport slave (
    input  data_valid_in, chan_in, data_in,
    output data_valid_out, chan_out, data_out, sat_out
  );
endinterface

// File: rtl/pid_filter_mc.sv
// rtl/pid_filter_mc.sv - N-channel time-multiplexed PID filter on one shared 4-stage pipe
// Stages: S0 accept/snapshot, S1 state read-modify-write, S2 multiply, S3 sum/clamp/output.
module pid_filter_mc #(
  parameter int N_CHAN = 8,
  parameter int W_CHAN = 3,
  parameter int W_IN   = 18,
  parameter int W_COEF = 16,
  parameter int W_INT  = 32,
  parameter int W_OUT  = 48
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  pid_filter_mc_if.slave           bus,
  input  logic signed [W_COEF-1:0] setpoint_in,
  input  logic signed [W_COEF-1:0] p_coef_in,
  input  logic signed [W_COEF-1:0] i_coef_in,
  input  logic signed [W_COEF-1:0] d_coef_in,
  input  logic [N_CHAN-1:0]        update_en_in,
  input  logic                     update_in,
  input  logic [N_CHAN-1:0]        lock_en_in
);
  localparam int W_E   = W_IN + 1;
  localparam int W_D   = W_IN + 2;
  localparam int W_IA  = ((W_INT > W_E) ? W_INT : W_E) + 1;
  localparam int W_PE  = W_COEF + W_E;
  localparam int W_IE  = W_COEF + W_INT;
  localparam int W_DE  = W_COEF + W_D;
  localparam int W_M1  = (W_PE > W_IE) ? W_PE : W_IE;
  localparam int W_M2  = (W_M1 > W_DE) ? W_M1 : W_DE;
  localparam int W_SUM = ((W_M2 > W_OUT) ? W_M2 : W_OUT) + 2;

  logic signed [W_COEF-1:0] r_sp    [N_CHAN];
  logic signed [W_COEF-1:0] r_p     [N_CHAN];
  logic signed [W_COEF-1:0] r_i     [N_CHAN];
  logic signed [W_COEF-1:0] r_d     [N_CHAN];
  logic signed [W_INT-1:0]  r_integ [N_CHAN];
  logic signed [W_E-1:0]    r_eprev [N_CHAN];

  logic                     r_s1_valid, r_s1_lock;
  logic [W_CHAN-1:0]        r_s1_chan;
  logic signed [W_E-1:0]    r_s1_e;
  logic signed [W_COEF-1:0] r_s1_p, r_s1_i, r_s1_d;

  logic                     r_s2_valid;
  logic [W_CHAN-1:0]        r_s2_chan;
  logic signed [W_E-1:0]    r_s2_e;
  logic signed [W_INT-1:0]  r_s2_integ;
  logic signed [W_D-1:0]    r_s2_deriv;
  logic signed [W_COEF-1:0] r_s2_p, r_s2_i, r_s2_d;

  logic                     r_s3_valid;
  logic [W_CHAN-1:0]        r_s3_chan;
  logic signed [W_PE-1:0]   r_s3_pe;
  logic signed [W_IE-1:0]   r_s3_ie;
  logic signed [W_DE-1:0]   r_s3_de;

  logic                     w_chan_ok, w_take;
  logic signed [W_COEF-1:0] w_sp;
  logic signed [W_E-1:0]    w_e;

  generate
    if (N_CHAN < (2 ** W_CHAN)) begin : g_chan_chk
      assign w_chan_ok = (32'(bus.chan_in) < N_CHAN);
    end else begin : g_chan_all
      assign w_chan_ok = 1'b1;
    end
  endgenerate

  assign w_take = bus.data_valid_in & w_chan_ok;
  assign w_sp   = r_sp[bus.chan_in];
  assign w_e    = W_E'(w_sp) - W_E'(bus.data_in);

  // Integrator sum is done wide enough for either operand, then clamped back to W_INT.
  logic signed [W_INT-1:0]  w_integ_old, w_integ_new;
  logic signed [W_E-1:0]    w_eprev;
  logic signed [W_IA-1:0]   w_isum;
  logic [W_IA-W_INT:0]      w_ihi;
  logic                     w_iovf;
  logic signed [W_D-1:0]    w_deriv;

  assign w_integ_old = r_integ[r_s1_chan];
  assign w_eprev     = r_eprev[r_s1_chan];
  assign w_isum      = W_IA'(w_integ_old) + W_IA'(r_s1_e);
  assign w_ihi       = w_isum[W_IA-1:W_INT-1];
  assign w_iovf      = ~((&w_ihi) | ~(|w_ihi));
  assign w_integ_new = w_iovf ? {w_isum[W_IA-1], {(W_INT-1){~w_isum[W_IA-1]}}}
                              : w_isum[W_INT-1:0];
  assign w_deriv     = W_D'(r_s1_e) - W_D'(w_eprev);

  logic signed [W_SUM-1:0]  w_sum;
  logic [W_SUM-W_OUT:0]     w_ohi;
  logic                     w_oovf;
  logic signed [W_OUT-1:0]  w_out;

  assign w_sum  = W_SUM'(r_s3_pe) + W_SUM'(r_s3_ie) + W_SUM'(r_s3_de);
  assign w_ohi  = w_sum[W_SUM-1:W_OUT-1];
  assign w_oovf = ~((&w_ohi) | ~(|w_ohi));
  assign w_out  = w_oovf ? {w_sum[W_SUM-1], {(W_OUT-1){~w_sum[W_SUM-1]}}}
                         : w_sum[W_OUT-1:0];

  // Coefficient and state banks; S1 writes state in the same cycle it reads it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int c = 0; c < N_CHAN; c++) begin
        r_sp[c]    <= '0;
        r_p[c]     <= '0;
        r_i[c]     <= '0;
        r_d[c]     <= '0;
        r_integ[c] <= '0;
        r_eprev[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CHAN; c++) begin
        if (update_in && update_en_in[c]) begin
          r_sp[c] <= setpoint_in;
          r_p[c]  <= p_coef_in;
          r_i[c]  <= i_coef_in;
          r_d[c]  <= d_coef_in;
        end
      end
      if (r_s1_valid) begin
        r_integ[r_s1_chan] <= r_s1_lock ? w_integ_new : '0;
        r_eprev[r_s1_chan] <= r_s1_lock ? r_s1_e : '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_s1_valid <= 1'b0;  r_s1_lock <= 1'b0;  r_s1_chan <= '0;  r_s1_e <= '0;
      r_s1_p <= '0;  r_s1_i <= '0;  r_s1_d <= '0;
      r_s2_valid <= 1'b0;  r_s2_chan <= '0;  r_s2_e <= '0;
      r_s2_integ <= '0;  r_s2_deriv <= '0;
      r_s2_p <= '0;  r_s2_i <= '0;  r_s2_d <= '0;
      r_s3_valid <= 1'b0;  r_s3_chan <= '0;
      r_s3_pe <= '0;  r_s3_ie <= '0;  r_s3_de <= '0;
      bus.data_valid_out <= 1'b0;
      bus.chan_out       <= '0;
      bus.data_out       <= '0;
      bus.sat_out        <= 1'b0;
    end else begin
      r_s1_valid <= w_take;
      r_s1_chan  <= bus.chan_in;
      r_s1_e     <= w_e;
      r_s1_p     <= r_p[bus.chan_in];
      r_s1_i     <= r_i[bus.chan_in];
      r_s1_d     <= r_d[bus.chan_in];
      r_s1_lock  <= lock_en_in[bus.chan_in];

      // An unlocked sample zeroes every product term, so its result is exactly 0.
      r_s2_valid <= r_s1_valid;
      r_s2_chan  <= r_s1_chan;
      r_s2_p     <= r_s1_p;
      r_s2_i     <= r_s1_i;
      r_s2_d     <= r_s1_d;
      r_s2_e     <= r_s1_lock ? r_s1_e : '0;
      r_s2_integ <= r_s1_lock ? w_integ_new : '0;
      r_s2_deriv <= r_s1_lock ? w_deriv : '0;

      r_s3_valid <= r_s2_valid;
      r_s3_chan  <= r_s2_chan;
      r_s3_pe    <= W_PE'(r_s2_p) * W_PE'(r_s2_e);
      r_s3_ie    <= W_IE'(r_s2_i) * W_IE'(r_s2_integ);
      r_s3_de    <= W_DE'(r_s2_d) * W_DE'(r_s2_deriv);

      bus.data_valid_out <= r_s3_valid;
      if (r_s3_valid) begin
        bus.chan_out <= r_s3_chan;
        bus.data_out <= w_out;
        bus.sat_out  <= w_oovf;
      end
    end
  end
endmodule

// File: tb/tb_pid_filter_mc.sv
// tb/tb_pid_filter_mc.sv - scoreboard bench for pid_filter_mc (default widths and W_INT=8/W_OUT=16)
module tb_pid_filter_mc;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic signed [15:0] sp_in, p_in, i_in, d_in;
  logic [7:0]         upd_mask, lock;
  logic               upd_a, upd_b;

  pid_filter_mc_if #(.W_CHAN(3), .W_IN(18), .W_OUT(48)) ifa ();
  pid_filter_mc_if #(.W_CHAN(3), .W_IN(18), .W_OUT(16)) ifb ();

  pid_filter_mc #(.N_CHAN(8), .W_CHAN(3), .W_IN(18), .W_COEF(16), .W_INT(32), .W_OUT(48)) dut_a (
    .clk_in(clk), .rst_in(rst), .bus(ifa),
    .setpoint_in(sp_in), .p_coef_in(p_in), .i_coef_in(i_in), .d_coef_in(d_in),
    .update_en_in(upd_mask), .update_in(upd_a), .lock_en_in(lock)
  );

  pid_filter_mc #(.N_CHAN(8), .W_CHAN(3), .W_IN(18), .W_COEF(16), .W_INT(8), .W_OUT(16)) dut_b (
    .clk_in(clk), .rst_in(rst), .bus(ifb),
    .setpoint_in(sp_in), .p_coef_in(p_in), .i_coef_in(i_in), .d_coef_in(d_in),
    .update_en_in(upd_mask), .update_in(upd_b), .lock_en_in(lock)
  );

  typedef struct {
    int     ch;
    longint u;
    bit     s;
    int     cyc;
  } exp_t;

  exp_t   q_a[$], q_b[$];
  longint log_a[$], log_b[$];
  bit     slog_b[$];
  int     n_chk = 0, n_err = 0, cyc = 0, n_out = 0;

  longint m_sp[2][8], m_p[2][8], m_i[2][8], m_d[2][8], m_integ[2][8], m_eprev[2][8];
  bit       pend[2];
  logic [7:0] pend_mask[2];
  longint   pend_v[2][4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, longint got, longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint clampw(longint v, int w, output bit s);
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -(longint'(1) <<< (w - 1));
    s = 1'b0;
    if (v > hi) begin s = 1'b1; return hi; end
    if (v < lo) begin s = 1'b1; return lo; end
    return v;
  endfunction

  function automatic longint rnd(int w);
    longint v = longint'($urandom) & ((longint'(1) <<< w) - 1);
    if (v[w-1]) v = v - (longint'(1) <<< w);
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t ex;
    if (ifa.data_valid_out) begin
      n_out++;
      if (q_a.size() == 0) chk("a_spurious", longint'(ifa.data_valid_out), 0);
      else begin
        ex = q_a.pop_front();
        chk("a_chan", ifa.chan_out, ex.ch);
        chk("a_u", ifa.data_out, ex.u);
        chk("a_sat", ifa.sat_out, ex.s);
        chk("a_latency", cyc, ex.cyc);
        log_a.push_back(ifa.data_out);
      end
    end
    if (ifb.data_valid_out) begin
      n_out++;
      if (q_b.size() == 0) chk("b_spurious", longint'(ifb.data_valid_out), 0);
      else begin
        ex = q_b.pop_front();
        chk("b_chan", ifb.chan_out, ex.ch);
        chk("b_u", ifb.data_out, ex.u);
        chk("b_sat", ifb.sat_out, ex.s);
        chk("b_latency", cyc, ex.cyc);
        log_b.push_back(ifb.data_out);
        slog_b.push_back(ifb.sat_out);
      end
    end
  end

  task automatic send(int k, int ch, longint x);
    longint e, integ, der, u;
    bit     s;
    exp_t   ex;
    int     wi = (k == 0) ? 32 : 8;
    int     wo = (k == 0) ? 48 : 16;
    e = m_sp[k][ch] - x;
    if (lock[ch]) begin
      integ = clampw(m_integ[k][ch] + e, wi, s);
      der = e - m_eprev[k][ch];
      m_integ[k][ch] = integ;
      m_eprev[k][ch] = e;
      u = m_p[k][ch] * e + m_i[k][ch] * integ + m_d[k][ch] * der;
    end else begin
      m_integ[k][ch] = 0;
      m_eprev[k][ch] = 0;
      u = 0;
    end
    ex.u = clampw(u, wo, s);
    ex.s = s;
    ex.ch = ch;
    ex.cyc = cyc + 4;
    if (k == 0) begin
      ifa.data_valid_in = 1'b1; ifa.chan_in = 3'(ch); ifa.data_in = x[17:0];
      q_a.push_back(ex);
    end else begin
      ifb.data_valid_in = 1'b1; ifb.chan_in = 3'(ch); ifb.data_in = x[17:0];
      q_b.push_back(ex);
    end
  endtask

  task automatic upd(int k, logic [7:0] mask, input longint sp, input longint p,
                     input longint i, input longint d);
    upd_mask = mask;
    sp_in = sp[15:0]; p_in = p[15:0]; i_in = i[15:0]; d_in = d[15:0];
    if (k == 0) upd_a = 1'b1; else upd_b = 1'b1;
    pend[k] = 1'b1;
    pend_mask[k] = mask;
    pend_v[k][0] = sp; pend_v[k][1] = p; pend_v[k][2] = i; pend_v[k][3] = d;
  endtask

  // Coefficient loads become visible to the model only after this cycle's samples.
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (pend[k]) begin
        for (int c = 0; c < 8; c++) begin
          if (pend_mask[k][c]) begin
            m_sp[k][c] = pend_v[k][0]; m_p[k][c] = pend_v[k][1];
            m_i[k][c]  = pend_v[k][2]; m_d[k][c] = pend_v[k][3];
          end
        end
        pend[k] = 1'b0;
      end
    end
    ifa.data_valid_in = 1'b0;
    ifb.data_valid_in = 1'b0;
    upd_a = 1'b0;
    upd_b = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q_a.size() + q_b.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifa.data_valid_in = 1'b0; ifb.data_valid_in = 1'b0;
    upd_a = 1'b0; upd_b = 1'b0;
    q_a.delete(); q_b.delete();
    for (int k = 0; k < 2; k++) begin
      pend[k] = 1'b0;
      for (int c = 0; c < 8; c++) begin
        m_sp[k][c] = 0; m_p[k][c] = 0; m_i[k][c] = 0; m_d[k][c] = 0;
        m_integ[k][c] = 0; m_eprev[k][c] = 0;
      end
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int base, nb;
    rst = 1'b1;
    sp_in = '0; p_in = '0; i_in = '0; d_in = '0;
    upd_mask = '0; lock = '0; upd_a = 1'b0; upd_b = 1'b0;
    ifa.chan_in = '0; ifa.data_in = '0; ifb.chan_in = '0; ifb.data_in = '0;
    @(negedge clk);
    do_reset();
    chk("rst_a_valid", ifa.data_valid_out, 0);
    chk("rst_a_chan", ifa.chan_out, 0);
    chk("rst_a_data", ifa.data_out, 0);
    chk("rst_a_sat", ifa.sat_out, 0);
    chk("rst_b_data", ifb.data_out, 0);

    // single channel, known values
    lock = 8'hFF;
    upd(0, 8'h01, 0, 10, 3, 2); step();
    base = log_a.size();
    send(0, 0, 5); step();
    send(0, 0, 5); step();
    drain();
    chk("t1_u0", log_a[base], -75);
    chk("t1_u1", log_a[base+1], -80);

    // random stream on ch0 with random coefficients
    upd(0, 8'h01, rnd(16), rnd(16), rnd(16), rnd(16)); step();
    for (int n = 0; n < 100; n++) begin
      send(0, 0, rnd(18)); step();
    end
    drain();

    // interleaved ch0/ch3, back-to-back runs included
    upd(0, 8'h08, 100, -7, 5, -11); step();
    for (int n = 0; n < 40; n++) begin
      send(0, ($urandom_range(0, 1) != 0) ? 3 : 0, rnd(18)); step();
    end
    drain();

    // anti-windup on the narrow instance
    upd(1, 8'h02, 0, 0, 1, 0); step();
    base = log_b.size();
    for (int n = 0; n < 3; n++) begin
      send(1, 1, 100); step();
    end
    drain();
    chk("t4_u0", log_b[base], -100);
    chk("t4_u1", log_b[base+1], -128);
    chk("t4_u2", log_b[base+2], -128);
    chk("t4_sat2", slog_b[base+2], 0);

    // output clamp
    upd(1, 8'h04, 0, 32767, 0, 0); step();
    base = log_b.size();
    send(1, 2, 131071); step();
    drain();
    chk("t5_u", log_b[base], -32768);
    chk("t5_sat", slog_b[base], 1);

    // update coincident with a sample
    upd(0, 8'h20, 0, 1, 0, 0); step();
    base = log_a.size();
    send(0, 5, -3); upd(0, 8'h20, 0, 100, 0, 0); step();
    send(0, 5, -3); step();
    drain();
    chk("t6_old_coef", log_a[base], 3);
    chk("t6_new_coef", log_a[base+1], 300);

    // lock 1->0->1 on ch6, back-to-back
    upd(0, 8'h40, 0, 1, 1, 1); step();
    base = log_a.size();
    send(0, 6, -2); step();
    lock[6] = 1'b0; send(0, 6, -2); step();
    lock[6] = 1'b1; send(0, 6, -2); step();
    drain();
    chk("t6_lock_u0", log_a[base], 6);
    chk("t6_unlock_u", log_a[base+1], 0);
    chk("t6_relock_u", log_a[base+2], 6);

    // reset with 3 samples in flight
    send(0, 3, 11); send(1, 1, 5); step();
    send(0, 0, 12); step();
    send(0, 3, 13); step();
    do_reset();
    nb = n_out;
    repeat (8) @(negedge clk);
    chk("rst_no_output", n_out - nb, 0);
    chk("rst2_a_data", ifa.data_out, 0);
    chk("rst2_a_chan", ifa.chan_out, 0);

    // banks cleared by reset
    base = log_a.size();
    send(0, 3, -50); step();
    upd(0, 8'h01, 0, 1, 1, 1); step();
    send(0, 0, -1); step();
    drain();
    chk("post_rst_coef0", log_a[base], 0);
    chk("post_rst_state", log_a[base+1], 3);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
